eth_mdio_phy_resp: RTL and testbench
====================================

// Module: eth_mdio_phy_resp
// PURPOSE
// Clause-22 MDIO responder (PHY-side management target). It is the counterpart of the eth_mdio initiator.
// It decodes read/write frames on MDIO and serves a 32x16 register file. A read returns data on MDIO;
// a write updates the register file and pulses a write strobe.
// Used as a PHY model in loopback/sim benches and in FPGA-to-FPGA management links. Tristate buffer lives in the top level.
// PARAMETERS
// gPhy_Addr      5'd1      PHYAD this responder answers to
// gPhy_Id1       16'h0007  read-only value of reg 2
// gPhy_Id2       16'hC0F1  read-only value of reg 3
// gPreamble_Len  32        consecutive 1s (1..32) required before ST
// PORTS
// Clk        in   1   MDC; all logic on rising edge
// Rst        in   1   async, active-high
// Mdio_I     in   1   MDIO pad input
// Link_Up    in   1   live link status, mirrored into reg1 bit 2
// Mdio_O     out  1   MDIO drive value
// Mdio_Oe    out  1   MDIO drive enable (1 = responder drives)
// Busy       out  1   high from ST detect until frame end
// Wr_Strb    out  1   one-cycle pulse on accepted write
// Wr_Addr    out  5   REGAD of accepted write
// Wr_Data    out  16  data of accepted write
// BEHAVIOUR
// - Reset (async): state=IDLE, ones_cnt=0, Mdio_O=0, Mdio_Oe=0, Busy=0, Wr_Strb=0, Wr_Addr=0, Wr_Data=0, regs=default.
// - All inputs are sampled on the rising edge; all outputs are registered. Frames are MSB first.
// - FSM: IDLE -> ST -> OP(2) -> PHYAD(5) -> REGAD(5) -> TA(2) -> DATA(16) -> IDLE.
// - IDLE: ones_cnt increments on 1 and saturates at 32; a 0 clears it.
//   A 0 with ones_cnt>=gPreamble_Len moves to ST (first ST bit consumed) and sets Busy.
// - ST: the second bit must be 1, else go to IDLE with ones_cnt=0.
// - OP: 10=read, 01=write. 00/11 -> IDLE, ones_cnt=0.
// - PHYAD != gPhy_Addr: the frame is still consumed to the end, but nothing is driven and nothing is written.
// - Read, on the edge sampling the last REGAD bit: snapshot reg into the shift register.
//   * Edges 1..2 after that edge: Mdio_Oe=0 for TA bit 1; then Mdio_Oe=1, Mdio_O=0 for TA bit 2.
//   * Then 16 periods of data MSB first. Mdio_Oe is high for exactly 17 periods and drops on the edge ending data bit 0.
// - Write: TA must sample 1,0. On a mismatch the data is consumed and the write is discarded.
//   On the edge sampling data bit 0 (PHYAD match, TA ok):
//   * update the register, then assert Wr_Strb for 1 cycle with Wr_Addr/Wr_Data stable.
//   * Wr_Strb also fires for RO regs; their contents are unchanged.
// - Frame end: IDLE, Busy=0, ones_cnt=0. The next frame needs a full preamble; back-to-back frames need no gap.
// - Register map:
//   * reg0: RW. Bit 15 self-clearing soft reset: it restores all regs to default and reg0 reads 16'h0000 afterwards.
//   * reg1: RO = 16'h7809 | (Link_Up<<2).
//   * reg2/3: RO = gPhy_Id1/gPhy_Id2.
//   * regs 4-31: RW, reset 16'h0000.
// - Read snapshot is taken once per frame: a Link_Up change or write mid-frame does not alter the data in flight.
// - Rst mid-frame: Mdio_Oe drops immediately (async) and no partial write is committed.
// TESTING
// - Reset: Oe=0, Busy=0, Wr_Strb=0; read reg2 at PHYAD 1 -> returns 16'h0007, Oe high exactly 17 MDC cycles, TA drive bit = 0.
// - Write reg4=16'hA5A5 -> Wr_Strb 1 cycle with Wr_Addr=4, Wr_Data=A5A5; read reg4 -> A5A5.
// - PHYAD=2 read and write -> Oe never asserted, no Wr_Strb, reg4 unchanged; Busy still pulses for the frame.
// - 31-one preamble then ST (gPreamble_Len=32) -> frame ignored; OP=11 -> ignored, next valid frame is served.
// - Link_Up=1: read reg1 -> 16'h780D; Link_Up=0 -> 16'h7809; toggle during data -> the snapshot value is returned.
// - Write reg0=16'h8000 -> reg4 reads 0, reg0 reads 0; Rst at read data bit 8 -> Oe=0 at once, next read correct.

Source files
------------

// File: rtl/eth_mdio_phy_resp.sv
// Clause-22 MDIO responder: decodes read/write frames on MDC/MDIO and serves a 32x16 register file.
// state | meaning: IDLE preamble hunt, ST second start bit, OP opcode, PHYAD/REGAD addresses, TA turnaround, DATA payload.
module eth_mdio_phy_resp #(
  parameter logic [4:0]  gPhy_Addr     = 5'd1,
  parameter logic [15:0] gPhy_Id1      = 16'h0007,
  parameter logic [15:0] gPhy_Id2      = 16'hC0F1,
  parameter int unsigned gPreamble_Len = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdio_i,
  input  logic        link_up,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        busy,
  output logic        wr_strb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [5:0]  ones_q;
  logic        is_rd_q, match_q, ta_ok_q;
  logic [14:0] sh_in_q;
  logic [15:0] sh_out_q;
  logic [4:0]  regad_q;
  logic [15:0] regs_q [32];

  logic        field_end, preamble_ok, drive;
  logic [4:0]  rd_addr;
  logic [15:0] rd_val, wdata;

  assign preamble_ok = (32'(ones_q) >= gPreamble_Len);
  assign drive       = is_rd_q && match_q;
  assign rd_addr     = {sh_in_q[3:0], mdio_i};
  assign wdata       = {sh_in_q[14:0], mdio_i};

  always_comb begin
    case (rd_addr)
      5'd1:    rd_val = 16'h7809 | {13'b0, link_up, 2'b0};
      5'd2:    rd_val = gPhy_Id1;
      5'd3:    rd_val = gPhy_Id2;
      default: rd_val = regs_q[rd_addr];
    endcase
  end

  always_comb begin
    field_end = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_OP, S_TA:       field_end = (cnt_q == 4'd1);
      S_PHYAD, S_REGAD: field_end = (cnt_q == 4'd4);
      S_DATA:           field_end = (cnt_q == 4'd15);
      default:          field_end = 1'b0;
    endcase
    case (state_q)
      S_IDLE:  if (!mdio_i && preamble_ok) state_d = S_ST;
      S_ST:    state_d = mdio_i ? S_OP : S_IDLE;
      // only 10 (read) and 01 (write) are legal opcodes
      S_OP:    if (field_end) state_d = (sh_in_q[0] ^ mdio_i) ? S_PHYAD : S_IDLE;
      S_PHYAD: if (field_end) state_d = S_REGAD;
      S_REGAD: if (field_end) state_d = S_TA;
      S_TA:    if (field_end) state_d = S_DATA;
      S_DATA:  if (field_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ones_q   <= '0;
      is_rd_q  <= 1'b0;
      match_q  <= 1'b0;
      ta_ok_q  <= 1'b0;
      sh_in_q  <= '0;
      sh_out_q <= '0;
      regad_q  <= '0;
      mdio_o   <= 1'b0;
      mdio_oe  <= 1'b0;
      busy     <= 1'b0;
      wr_strb  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      wr_strb <= 1'b0;
      sh_in_q <= {sh_in_q[13:0], mdio_i};
      if (state_q == S_IDLE || state_q == S_ST || field_end) cnt_q <= '0;
      else                                                  cnt_q <= cnt_q + 4'd1;

      case (state_q)
        S_IDLE: begin
          if (mdio_i) begin
            if (ones_q != 6'd32) ones_q <= ones_q + 6'd1;
          end else begin
            ones_q <= '0;
          end
          if (state_d == S_ST) busy <= 1'b1;
        end
        S_ST: if (!mdio_i) busy <= 1'b0;
        S_OP: if (field_end) begin
          is_rd_q <= sh_in_q[0];
          if (state_d == S_IDLE) busy <= 1'b0;
        end
        S_PHYAD: if (field_end) match_q <= (rd_addr == gPhy_Addr);
        S_REGAD: if (field_end) begin
          regad_q  <= rd_addr;
          sh_out_q <= rd_val;
        end
        S_TA: begin
          if (cnt_q == 4'd0) begin
            ta_ok_q <= mdio_i;
            if (drive) begin
              mdio_oe <= 1'b1;
              mdio_o  <= 1'b0;
            end
          end else begin
            ta_ok_q <= ta_ok_q & ~mdio_i;
            if (drive) begin
              mdio_o   <= sh_out_q[15];
              sh_out_q <= {sh_out_q[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          if (!field_end) begin
            if (drive) begin
              mdio_o   <= sh_out_q[15];
              sh_out_q <= {sh_out_q[14:0], 1'b0};
            end
          end else begin
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b0;
            busy    <= 1'b0;
            ones_q  <= '0;
            if (!is_rd_q && match_q && ta_ok_q) begin
              wr_strb <= 1'b1;
              wr_addr <= regad_q;
              wr_data <= wdata;
              // soft reset self-clears: every register, reg0 included, returns to zero
              if (regad_q == 5'd0 && wdata[15]) begin
                for (int i = 0; i < 32; i++) regs_q[i] <= '0;
              end else if (regad_q == 5'd0 || regad_q >= 5'd4) begin
                regs_q[regad_q] <= wdata;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_phy_resp.sv
// Directed bench for eth_mdio_phy_resp: drives MDIO frames bit by bit and checks the responder's drive,
// strobes and register contents against hand-computed values.
module tb_eth_mdio_phy_resp;

  logic        clk = 1'b0;
  logic        rst, mdio_i, link_up;
  logic        mdio_o, mdio_oe, busy, wr_strb;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] ob_rd, ob_wdata;
  logic [4:0]  ob_waddr;
  int          ob_oe, ob_busy, ob_strb;
  logic        ob_ta1_oe, ob_ta2_oe, ob_ta2_o, ob_rst_oe;

  always #5 clk = ~clk;

  eth_mdio_phy_resp dut (
    .clk(clk), .rst(rst), .mdio_i(mdio_i), .link_up(link_up),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .busy(busy),
    .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Drives pre ones, then ST/OP/PHYAD/REGAD/TA/DATA, then n_trail zeros. Outputs are sampled on the
  // falling edge just before each new bit is driven, i.e. the value the responder presents for that bit.
  // act 1 toggles link_up after bit act_k is driven; act 2 pulses rst in the middle of that bit.
  task automatic xfer(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                      input logic [1:0] ta, input logic [15:0] data, input int n_trail,
                      input int act_k, input int act);
    logic [31:0] fr;
    int total;
    fr = {2'b01, op, phy, ra, ta, data};
    total = pre + 32 + n_trail;
    ob_rd = '0; ob_wdata = '0; ob_waddr = '0;
    ob_oe = 0; ob_busy = 0; ob_strb = 0;
    ob_ta1_oe = 1'b1; ob_ta2_oe = 1'b0; ob_ta2_o = 1'b1; ob_rst_oe = 1'b1;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k > 0) begin
        ob_oe   += int'(mdio_oe);
        ob_busy += int'(busy);
        if (wr_strb) begin
          ob_strb++;
          ob_waddr = wr_addr;
          ob_wdata = wr_data;
        end
        if (k >= pre + 16 && k <= pre + 31) ob_rd[pre + 31 - k] = mdio_o;
        if (k == pre + 14) ob_ta1_oe = mdio_oe;
        if (k == pre + 15) begin ob_ta2_oe = mdio_oe; ob_ta2_o = mdio_o; end
      end
      if (k < pre)           mdio_i = 1'b1;
      else if (k < pre + 32) mdio_i = fr[31 - (k - pre)];
      else                   mdio_i = 1'b0;
      if (k == act_k) begin
        if (act == 1) link_up = ~link_up;
        else if (act == 2) begin
          #2 rst = 1'b1;
          #1 ob_rst_oe = mdio_oe;
          #1 rst = 1'b0;
        end
      end
    end
  endtask

  task automatic rd(input logic [4:0] phy, input logic [4:0] ra);
    xfer(32, 2'b10, phy, ra, 2'b11, 16'hFFFF, 2, -1, 0);
  endtask

  task automatic wr(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d, input logic [1:0] ta);
    xfer(32, 2'b01, phy, ra, ta, d, 2, -1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; mdio_i = 1'b1; link_up = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mdio_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", mdio_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_strb !== 1'b0) begin failures++; $display("FAIL reset_strb got=%b exp=0", wr_strb); end
    checks++; if (wr_addr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", wr_addr); end
    checks++; if (wr_data !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wr_data); end
    rst = 1'b0;
    rd(5'd1, 5'd2);
    checks++; if (ob_rd !== 16'h0007) begin failures++; $display("FAIL id1_data got=%h exp=0007", ob_rd); end
    checks++; if (ob_oe != 17) begin failures++; $display("FAIL id1_oe_cycles got=%0d exp=17", ob_oe); end
    checks++; if (ob_ta1_oe !== 1'b0) begin failures++; $display("FAIL ta1_oe got=%b exp=0", ob_ta1_oe); end
    checks++; if (ob_ta2_oe !== 1'b1 || ob_ta2_o !== 1'b0) begin failures++; $display("FAIL ta2_drive got oe=%b o=%b exp oe=1 o=0", ob_ta2_oe, ob_ta2_o); end
    checks++; if (ob_busy != 31) begin failures++; $display("FAIL id1_busy got=%0d exp=31", ob_busy); end
    checks++; if (ob_strb != 0) begin failures++; $display("FAIL read_strb got=%0d exp=0", ob_strb); end
    rd(5'd1, 5'd3);
    checks++; if (ob_rd !== 16'hC0F1) begin failures++; $display("FAIL id2_data got=%h exp=C0F1", ob_rd); end
  endtask

  task automatic test_write();
    wr(5'd1, 5'd4, 16'hA5A5, 2'b10);
    checks++; if (ob_strb != 1) begin failures++; $display("FAIL wr4_strb got=%0d exp=1", ob_strb); end
    checks++; if (ob_waddr !== 5'd4) begin failures++; $display("FAIL wr4_addr got=%h exp=04", ob_waddr); end
    checks++; if (ob_wdata !== 16'hA5A5) begin failures++; $display("FAIL wr4_data got=%h exp=A5A5", ob_wdata); end
    checks++; if (ob_oe != 0) begin failures++; $display("FAIL wr4_oe got=%0d exp=0", ob_oe); end
    rd(5'd1, 5'd4);
    checks++; if (ob_rd !== 16'hA5A5) begin failures++; $display("FAIL rd4 got=%h exp=A5A5", ob_rd); end
    wr(5'd1, 5'd0, 16'h1234, 2'b10);
    rd(5'd1, 5'd0);
    checks++; if (ob_rd !== 16'h1234) begin failures++; $display("FAIL rd0 got=%h exp=1234", ob_rd); end
    wr(5'd1, 5'd2, 16'h5A5A, 2'b10);
    checks++; if (ob_strb != 1 || ob_waddr !== 5'd2) begin failures++; $display("FAIL ro_strb got=%0d addr=%h exp=1 addr=02", ob_strb, ob_waddr); end
    rd(5'd1, 5'd2);
    checks++; if (ob_rd !== 16'h0007) begin failures++; $display("FAIL ro_keep got=%h exp=0007", ob_rd); end
    wr(5'd1, 5'd5, 16'h5555, 2'b11);
    checks++; if (ob_strb != 0) begin failures++; $display("FAIL bad_ta_strb got=%0d exp=0", ob_strb); end
    rd(5'd1, 5'd5);
    checks++; if (ob_rd !== 16'h0000) begin failures++; $display("FAIL bad_ta_reg got=%h exp=0000", ob_rd); end
  endtask

  task automatic test_phyad();
    rd(5'd2, 5'd4);
    checks++; if (ob_oe != 0) begin failures++; $display("FAIL other_phy_rd_oe got=%0d exp=0", ob_oe); end
    checks++; if (ob_busy != 31) begin failures++; $display("FAIL other_phy_busy got=%0d exp=31", ob_busy); end
    wr(5'd2, 5'd4, 16'h1111, 2'b10);
    checks++; if (ob_strb != 0) begin failures++; $display("FAIL other_phy_strb got=%0d exp=0", ob_strb); end
    checks++; if (ob_busy != 31) begin failures++; $display("FAIL other_phy_wr_busy got=%0d exp=31", ob_busy); end
    rd(5'd1, 5'd4);
    checks++; if (ob_rd !== 16'hA5A5) begin failures++; $display("FAIL other_phy_keep got=%h exp=A5A5", ob_rd); end
  endtask

  task automatic test_framing();
    xfer(31, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF, 2, -1, 0);
    checks++; if (ob_oe != 0 || ob_busy != 0) begin failures++; $display("FAIL short_pre got oe=%0d busy=%0d exp 0 0", ob_oe, ob_busy); end
    xfer(32, 2'b11, 5'd1, 5'd2, 2'b11, 16'hFFFF, 2, -1, 0);
    checks++; if (ob_oe != 0 || ob_strb != 0) begin failures++; $display("FAIL op11 got oe=%0d strb=%0d exp 0 0", ob_oe, ob_strb); end
    rd(5'd1, 5'd3);
    checks++; if (ob_rd !== 16'hC0F1 || ob_oe != 17) begin failures++; $display("FAIL after_op11 got=%h oe=%0d exp=C0F1 oe=17", ob_rd, ob_oe); end
  endtask

  task automatic test_back_to_back();
    xfer(32, 2'b01, 5'd1, 5'd6, 2'b10, 16'h3C96, 0, -1, 0);
    rd(5'd1, 5'd6);
    checks++; if (ob_rd !== 16'h3C96 || ob_oe != 17) begin failures++; $display("FAIL b2b got=%h oe=%0d exp=3C96 oe=17", ob_rd, ob_oe); end
  endtask

  task automatic test_link();
    link_up = 1'b1;
    rd(5'd1, 5'd1);
    checks++; if (ob_rd !== 16'h780D) begin failures++; $display("FAIL link_up got=%h exp=780D", ob_rd); end
    link_up = 1'b0;
    rd(5'd1, 5'd1);
    checks++; if (ob_rd !== 16'h7809) begin failures++; $display("FAIL link_dn got=%h exp=7809", ob_rd); end
    link_up = 1'b1;
    xfer(32, 2'b10, 5'd1, 5'd1, 2'b11, 16'hFFFF, 2, 32 + 18, 1);
    checks++; if (ob_rd !== 16'h780D) begin failures++; $display("FAIL link_snapshot got=%h exp=780D", ob_rd); end
    checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL link_toggle got=%b exp=0", link_up); end
  endtask

  task automatic test_soft_reset();
    wr(5'd1, 5'd0, 16'h8000, 2'b10);
    checks++; if (ob_strb != 1 || ob_wdata !== 16'h8000) begin failures++; $display("FAIL soft_strb got=%0d data=%h exp=1 data=8000", ob_strb, ob_wdata); end
    rd(5'd1, 5'd4);
    checks++; if (ob_rd !== 16'h0000) begin failures++; $display("FAIL soft_reg4 got=%h exp=0000", ob_rd); end
    rd(5'd1, 5'd0);
    checks++; if (ob_rd !== 16'h0000) begin failures++; $display("FAIL soft_reg0 got=%h exp=0000", ob_rd); end
  endtask

  task automatic test_async_reset();
    wr(5'd1, 5'd7, 16'hBEEF, 2'b10);
    rd(5'd1, 5'd7);
    checks++; if (ob_rd !== 16'hBEEF) begin failures++; $display("FAIL rd7 got=%h exp=BEEF", ob_rd); end
    xfer(32, 2'b10, 5'd1, 5'd7, 2'b11, 16'hFFFF, 2, 32 + 23, 2);
    checks++; if (ob_rst_oe !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", ob_rst_oe); end
    checks++; if (ob_oe != 9) begin failures++; $display("FAIL rst_oe_cycles got=%0d exp=9", ob_oe); end
    rd(5'd1, 5'd2);
    checks++; if (ob_rd !== 16'h0007 || ob_oe != 17) begin failures++; $display("FAIL post_rst got=%h oe=%0d exp=0007 oe=17", ob_rd, ob_oe); end
    rd(5'd1, 5'd7);
    checks++; if (ob_rd !== 16'h0000) begin failures++; $display("FAIL post_rst_reg7 got=%h exp=0000", ob_rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_phyad();
    test_framing();
    test_back_to_back();
    test_link();
    test_soft_reset();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
